// File: rtl/dev_hex_display_pkg.sv
// Shared constants and nibble decode for the hex display.
// Segment patterns are gfedcba, active high.
package pkg_hex;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] decode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/dev_hex_display_hex7seg_decode.sv
// Combinational nibble to 7-segment pattern.
// Thin wrapper so the table can be exercised alone.
module hex7seg_decode
  import pkg_hex::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pattern
);

  // table lookup
  always_comb begin
    pattern = decode(nib);
  end

endmodule

// File: rtl/dev_hex_display.sv
// Two-digit multiplexed 7-segment driver.
// Shows hex_val as two hex digits with per-slot blanking.
module dev_hex_display
  import pkg_hex::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int SWITCH_HZ    = 1_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hex_val,
  output logic       digit_sel,
  output logic [6:0] seg_pins
);

  localparam int DIGIT_CYCLES =
    (SWITCH_HZ == 0) ? 1 : CLK_FREQ / SWITCH_HZ;
  localparam int CW =
    (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  if (SWITCH_HZ == 0) begin : g_bad_hz
    $error("SWITCH_HZ must be nonzero");
  end
  if (DIGIT_CYCLES < 1) begin : g_bad_dc
    $error("DIGIT_CYCLES must be at least 1");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_bl
    $error("BLANK_CYCLES must be in [0, DIGIT_CYCLES)");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wrap;
  logic          sel_next;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    pattern;

  // next-state for slot counter and digit select
  always_comb begin
    wrap     = (cnt == CNT_LAST);
    cnt_next = wrap ? '0 : cnt + 1'b1;
    sel_next = wrap ? ~digit_sel : digit_sel;
    blank    = (int'(cnt_next) < BLANK_CYCLES);
    nib      = sel_next ? hex_val[7:4] : hex_val[3:0];
  end

  hex7seg_decode u_dec (
    .nib     (nib),
    .pattern (pattern)
  );

  // segments follow next-state select so they never lag the digit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_sel <= 1'b0;
      seg_pins  <= SEG_OFF;
    end else begin
      cnt       <= cnt_next;
      digit_sel <= sel_next;
      seg_pins  <= blank ? SEG_OFF : pattern;
    end
  end

endmodule

// File: tb/tb_dev_hex_display.sv
// Directed bench for dev_hex_display.
// DIGIT_CYCLES = 10, BLANK_CYCLES = 2, plus a no-blank instance.
module tb_dev_hex_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hex_val = 8'h00;
  logic [7:0] hex_nb = 8'h88;
  logic       digit_sel;
  logic [6:0] seg_pins;
  logic       sel_nb;
  logic [6:0] seg_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dev_hex_display #(
    .CLK_FREQ     (40),
    .SWITCH_HZ    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hex_val   (hex_val),
    .digit_sel (digit_sel),
    .seg_pins  (seg_pins)
  );

  dev_hex_display #(
    .CLK_FREQ     (40),
    .SWITCH_HZ    (4),
    .BLANK_CYCLES (0)
  ) dut_nb (
    .clk       (clk),
    .rst       (rst),
    .hex_val   (hex_nb),
    .digit_sel (sel_nb),
    .seg_pins  (seg_nb)
  );

  typedef struct {
    logic [7:0] hex;
    logic [6:0] right;
    logic [6:0] left;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_sel(input logic v, input string name);
    int n;
    n = 0;
    while (digit_sel !== v && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(digit_sel === v), 32'd1);
  endtask

  initial begin
    int nonblank;
    int lowcnt;
    logic exp_sel;
    logic [6:0] exp_seg;

    vecs[0]  = '{8'h00, 7'h3F, 7'h3F};
    vecs[1]  = '{8'h11, 7'h06, 7'h06};
    vecs[2]  = '{8'h22, 7'h5B, 7'h5B};
    vecs[3]  = '{8'h33, 7'h4F, 7'h4F};
    vecs[4]  = '{8'h44, 7'h66, 7'h66};
    vecs[5]  = '{8'h55, 7'h6D, 7'h6D};
    vecs[6]  = '{8'h66, 7'h7D, 7'h7D};
    vecs[7]  = '{8'h77, 7'h07, 7'h07};
    vecs[8]  = '{8'h88, 7'h7F, 7'h7F};
    vecs[9]  = '{8'h99, 7'h6F, 7'h6F};
    vecs[10] = '{8'hAA, 7'h77, 7'h77};
    vecs[11] = '{8'hBB, 7'h7C, 7'h7C};
    vecs[12] = '{8'hCC, 7'h39, 7'h39};
    vecs[13] = '{8'hDD, 7'h5E, 7'h5E};
    vecs[14] = '{8'hEE, 7'h79, 7'h79};
    vecs[15] = '{8'hFF, 7'h71, 7'h71};
    vecs[16] = '{8'h3C, 7'h39, 7'h4F};

    // 1. reset held
    rst = 1'b1;
    hex_val = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sel", 32'(digit_sel), 32'd0);
      chk("rst_seg", 32'(seg_pins), 32'h00);
    end

    // 2. multiplex sequence, k edges after release
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_sel = ((k / 10) % 2) == 1;
      if ((k % 10) < 2) exp_seg = 7'h00;
      else exp_seg = exp_sel ? 7'h77 : 7'h6D;
      chk($sformatf("mux_sel_k%0d", k), 32'(digit_sel), 32'(exp_sel));
      chk($sformatf("mux_seg_k%0d", k), 32'(seg_pins), 32'(exp_seg));
    end

    // 3. decode sweep, one full period per vector
    for (int v = 0; v < 17; v++) begin
      hex_val = vecs[v].hex;
      nonblank = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (seg_pins != 7'h00) begin
          nonblank++;
          chk($sformatf("dec_%02h_sel%0d", vecs[v].hex, digit_sel),
              32'(seg_pins),
              32'(digit_sel ? vecs[v].left : vecs[v].right));
        end
      end
      chk($sformatf("dec_%02h_lit", vecs[v].hex), 32'(nonblank), 32'd16);
    end

    // 4. live update mid-slot on the right digit
    hex_val = 8'h12;
    wait_sel(1'b1, "live_wait1");
    wait_sel(1'b0, "live_wait0");
    tick(); tick(); tick();
    chk("live_before", 32'(seg_pins), 32'h5B);
    hex_val = 8'h34;
    tick();
    chk("live_after", 32'(seg_pins), 32'h66);
    chk("live_sel", 32'(digit_sel), 32'd0);

    // 5. reset pulse at cnt=5 of the left slot
    wait_sel(1'b1, "mrst_wait");
    for (int i = 0; i < 5; i++) tick();
    chk("mrst_pre_sel", 32'(digit_sel), 32'd1);
    chk("mrst_pre_seg", 32'(seg_pins), 32'h4F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_sel", 32'(digit_sel), 32'd0);
    chk("mrst_seg", 32'(seg_pins), 32'h00);
    lowcnt = 1;
    for (int i = 0; i < 30 && digit_sel == 1'b0; i++) begin
      tick();
      if (digit_sel == 1'b0) lowcnt++;
    end
    chk("mrst_slot_len", 32'(lowcnt), 32'd10);

    // 6. no-blank instance after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("nb_seg_k%0d", k), 32'(seg_nb), 32'h7F);
      chk($sformatf("nb_sel_k%0d", k), 32'(sel_nb),
          32'((k / 10) % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
